// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: op codes, FSM states and the
// default memory window.
package lsu_pkg;

    typedef enum logic [2:0] {
        LSU_LB  = 3'd0,
        LSU_LH  = 3'd1,
        LSU_LW  = 3'd2,
        LSU_LBU = 3'd3,
        LSU_LHU = 3'd4,
        LSU_SB  = 3'd5,
        LSU_SH  = 3'd6,
        LSU_SW  = 3'd7
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [31:0] LSU_BASE_ADDR   = 32'h0040_0000;
    localparam int          LSU_DEPTH_WORDS = 64;

    function automatic logic lsu_is_store(input lsu_op_e op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte/halfword lane handling: load extraction with sign/zero
// extension and sub-word store merging. Only built when LSU_SUBWORD_EN is defined.
`ifdef LSU_SUBWORD_EN
import lsu_pkg::*;

module lsu_lane_align (
    input  logic [31:0] word,
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    lsu_op_e     op_e;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign op_e     = lsu_op_e'(op);
    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        load_data = word;
        case (op_e)
            LSU_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: load_data = {24'h0, byte_sel};
            LSU_LH:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
    end

    // Each byte lane independently picks either the old byte or store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic hit;
            logic [7:0] src;
            assign hit = ((op_e == LSU_SB) && (lane == LANE)) ||
                         ((op_e == LSU_SH) && (lane[1] == LANE[1]));
            assign src = (op_e == LSU_SB) ? wdata[7:0] : wdata[8*(gi % 2) +: 8];
            assign store_word[8*gi +: 8] = hit ? src : word[8*gi +: 8];
        end
    endgenerate

endmodule
`endif

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for the word-addressed data memory.
// Sub-word ops (byte/halfword, read-modify-write stores) require LSU_SUBWORD_EN.
import lsu_pkg::*;

module load_store_unit #(
    parameter logic [31:0] BASE_ADDR   = LSU_BASE_ADDR,
    parameter int          DEPTH_WORDS = LSU_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_dir,
    output logic [31:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wd,
    input  logic [31:0] mem_data_out
);

    // 33-bit limit so a window ending at the top of the address space cannot wrap.
    localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    lsu_state_e  state_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic [31:0] resp_rdata_reg;
    logic        resp_err_reg;
    logic [31:0] mem_dir_reg;
    logic [31:0] mem_data_in_reg;
    logic        mem_rd_reg;
    logic        mem_wd_reg;

    lsu_op_e     op_in;
    logic [32:0] addr_ext;
    logic        in_range;
    logic        bad_op;
    logic        req_err;

    assign op_in    = lsu_op_e'(req_op);
    assign addr_ext = {1'b0, req_addr};
    assign in_range = (addr_ext >= {1'b0, BASE_ADDR}) && (addr_ext < ADDR_LIMIT);
    assign req_err  = !in_range || bad_op;

    always_comb begin
        bad_op = 1'b0;
        case (op_in)
            LSU_LW, LSU_SW:          bad_op = |req_addr[1:0];
`ifdef LSU_SUBWORD_EN
            LSU_LH, LSU_LHU, LSU_SH: bad_op = req_addr[0];
            default:                 bad_op = 1'b0;
`else
            default:                 bad_op = 1'b1;
`endif
        endcase
    end

`ifdef LSU_SUBWORD_EN
    lsu_op_e     op_reg;
    logic [1:0]  lane_reg;
    logic [15:0] wdata_reg;
    logic [31:0] load_data;
    logic [31:0] store_word;

    lsu_lane_align u_lane_align (
        .word       (mem_data_out),
        .op         (op_reg),
        .lane       (lane_reg),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            req_ready_reg   <= 1'b1;
            resp_valid_reg  <= 1'b0;
            resp_rdata_reg  <= 32'h0;
            resp_err_reg    <= 1'b0;
            mem_dir_reg     <= 32'h0;
            mem_data_in_reg <= 32'h0;
            mem_rd_reg      <= 1'b0;
            mem_wd_reg      <= 1'b0;
`ifdef LSU_SUBWORD_EN
            op_reg          <= LSU_LB;
            lane_reg        <= 2'b00;
            wdata_reg       <= 16'h0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        req_ready_reg <= 1'b0;
                        mem_dir_reg   <= {req_addr[31:2], 2'b00};
`ifdef LSU_SUBWORD_EN
                        op_reg        <= op_in;
                        lane_reg      <= req_addr[1:0];
                        wdata_reg     <= req_wdata[15:0];
`endif
                        if (req_err) begin
                            state_reg      <= ST_RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'h0;
                        end else if (op_in == LSU_SW) begin
                            state_reg       <= ST_WRITE;
                            mem_wd_reg      <= 1'b1;
                            mem_data_in_reg <= req_wdata;
                        end else begin
                            state_reg  <= ST_READ;
                            mem_rd_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_rd_reg <= 1'b0;
`ifdef LSU_SUBWORD_EN
                    if (lsu_is_store(op_reg)) begin
                        state_reg       <= ST_WRITE;
                        mem_wd_reg      <= 1'b1;
                        mem_data_in_reg <= store_word;
                    end else begin
                        state_reg      <= ST_RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_data;
                    end
`else
                    state_reg      <= ST_RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= mem_data_out;
`endif
                end
                ST_WRITE: begin
                    mem_wd_reg     <= 1'b0;
                    state_reg      <= ST_RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= 32'h0;
                end
                ST_RESP: begin
                    resp_valid_reg <= 1'b0;
                    resp_err_reg   <= 1'b0;
                    resp_rdata_reg <= 32'h0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign resp_valid  = resp_valid_reg;
    assign resp_rdata  = resp_rdata_reg;
    assign resp_err    = resp_err_reg;
    assign mem_dir     = mem_dir_reg;
    assign mem_data_in = mem_data_in_reg;
    // A reset landing mid-transaction must never let a strobe reach memory.
    assign mem_rd      = mem_rd_reg && !rst;
    assign mem_wd      = mem_wd_reg && !rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small behavioural data memory.
// Sub-word cases are exercised when LSU_SUBWORD_EN is defined.
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h0040_0000;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_dir;
    logic [31:0] mem_data_in;
    logic        mem_rd;
    logic        mem_wd;
    logic [31:0] mem_data_out;

    int n_total = 0;
    int n_bad   = 0;

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_dir      (mem_dir),
        .mem_data_in  (mem_data_in),
        .mem_rd       (mem_rd),
        .mem_wd       (mem_wd),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural memory: read data appears at the falling edge of a read cycle.
    logic [31:0] mem [0:63];
    logic [31:0] mem_off;
    logic [5:0]  mem_idx;
    int          rd_cnt = 0;
    int          wd_cnt = 0;
    logic        both_hi = 1'b0;
    logic [31:0] last_wdata = 32'h0;

    assign mem_off = mem_dir - BASE;
    assign mem_idx = mem_off[7:2];

    always @(negedge clk) begin
        if (mem_rd) mem_data_out <= mem[mem_idx];
    end

    always @(posedge clk) begin
        if (mem_wd) begin
            mem[mem_idx] <= mem_data_in;
            last_wdata   <= mem_data_in;
            wd_cnt       <= wd_cnt + 1;
        end
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_rd && mem_wd) both_hi <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One full request; returns response fields, latency in cycles and strobe counts.
    task automatic lsu_xact(input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err,
                            output int lat, output int rds, output int wds);
        int rd0;
        int wd0;
        rd0 = rd_cnt;
        wd0 = wd_cnt;
        check("ready_before_req", 32'(req_ready), 32'd1);
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!resp_valid) lat = 99;
        rdata = resp_rdata;
        err   = resp_err;
        @(posedge clk); #1;
        check("resp_one_cycle", 32'(resp_valid), 32'd0);
        rds = rd_cnt - rd0;
        wds = wd_cnt - wd0;
        $display("xact op=%0d addr=%h wdata=%h -> rdata=%h err=%0b lat=%0d rd=%0d wd=%0d",
                 op, addr, wdata, rdata, err, lat, rds, wds);
    endtask

    task automatic expect_ok_load(input string tag, input logic [2:0] op,
                                  input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        int          lt, nr, nw;
        lsu_xact(op, addr, 32'h0, rd, er, lt, nr, nw);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_lat"}, 32'(lt), 32'd2);
        check({tag, "_rd"}, 32'(nr), 32'd1);
    endtask

    task automatic expect_sw(input string tag, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        er;
        int          lt, nr, nw;
        lsu_xact(OP_SW, addr, data, rd, er, lt, nr, nw);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_lat"}, 32'(lt), 32'd2);
        check({tag, "_wd"}, 32'(nw), 32'd1);
        check({tag, "_rd"}, 32'(nr), 32'd0);
        check({tag, "_wdata"}, last_wdata, data);
    endtask

    task automatic expect_err(input string tag, input logic [2:0] op, input logic [31:0] addr);
        logic [31:0] rd;
        logic        er;
        int          lt, nr, nw;
        lsu_xact(op, addr, 32'hFFFF_FFFF, rd, er, lt, nr, nw);
        check({tag, "_err"}, 32'(er), 32'd1);
        check({tag, "_data"}, rd, 32'h0);
        check({tag, "_lat"}, 32'(lt), 32'd1);
        check({tag, "_strobes"}, 32'(nr + nw), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt, nr, nw;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_dir", mem_dir, 32'h0);
        check("rst_mem_data_in", mem_data_in, 32'h0);
        check("rst_strobes", 32'({mem_rd, mem_wd}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store/load round trip, including the last valid word.
        expect_sw("sw_08", 32'h0040_0008, 32'hDEAD_BEEF);
        expect_ok_load("lw_08", OP_LW, 32'h0040_0008, 32'hDEAD_BEEF);
        expect_sw("sw_top", 32'h0040_00FC, 32'hCAFE_F00D);
        expect_ok_load("lw_top", OP_LW, 32'h0040_00FC, 32'hCAFE_F00D);
        expect_sw("sw_10", 32'h0040_0010, 32'h80FF_7F01);
        expect_sw("sw_20", 32'h0040_0020, 32'h1122_3344);
        expect_sw("sw_24", 32'h0040_0024, 32'h1122_3344);

        // Alignment and range errors.
        expect_err("err_lw_mis", OP_LW, 32'h0040_0002);
        expect_err("err_sh_mis", OP_SH, 32'h0040_0001);
        expect_err("err_below", OP_LW, 32'h003F_FFFC);
        expect_err("err_above", OP_SW, 32'h0040_0100);
        expect_err("err_wrap", OP_LW, 32'hFFFF_FFFC);

`ifdef LSU_SUBWORD_EN
        expect_ok_load("lb_13", OP_LB, 32'h0040_0013, 32'hFFFF_FF80);
        expect_ok_load("lbu_13", OP_LBU, 32'h0040_0013, 32'h0000_0080);
        expect_ok_load("lh_12", OP_LH, 32'h0040_0012, 32'hFFFF_80FF);
        expect_ok_load("lhu_10", OP_LHU, 32'h0040_0010, 32'h0000_7F01);
        expect_ok_load("lb_11", OP_LB, 32'h0040_0011, 32'h0000_007F);

        lsu_xact(OP_SB, 32'h0040_0025, 32'h0000_00AA, rd, er, lt, nr, nw);
        check("sb_err", 32'(er), 32'd0);
        check("sb_lat", 32'(lt), 32'd3);
        check("sb_rd", 32'(nr), 32'd1);
        check("sb_wd", 32'(nw), 32'd1);
        check("sb_merge", last_wdata, 32'h1122_AA44);
        check("sb_rdata", rd, 32'h0);

        lsu_xact(OP_SH, 32'h0040_0026, 32'h1234_BEEF, rd, er, lt, nr, nw);
        check("sh_lat", 32'(lt), 32'd3);
        check("sh_merge", last_wdata, 32'hBEEF_AA44);
        expect_ok_load("lw_24", OP_LW, 32'h0040_0024, 32'hBEEF_AA44);

        // Reset during the write half of an SB: memory must remain untouched.
        req_op    = OP_SB;
        req_addr  = 32'h0040_0020;
        req_wdata = 32'h0000_0055;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rmw_rst_wd", 32'(mem_wd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rmw_rst_ready", 32'(req_ready), 32'd1);
        expect_ok_load("rmw_rst_lw", OP_LW, 32'h0040_0020, 32'h1122_3344);
`else
        expect_err("nosub_lb", OP_LB, 32'h0040_0000);
        expect_err("nosub_lhu", OP_LHU, 32'h0040_0010);
        expect_err("nosub_sb", OP_SB, 32'h0040_0024);
        expect_ok_load("nosub_lw", OP_LW, 32'h0040_0024, 32'h1122_3344);

        // Reset during the write cycle of an SW: memory must remain untouched.
        req_op    = OP_SW;
        req_addr  = 32'h0040_0020;
        req_wdata = 32'h0000_0055;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("sw_rst_wd", 32'(mem_wd), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("sw_rst_ready", 32'(req_ready), 32'd1);
        expect_ok_load("sw_rst_lw", OP_LW, 32'h0040_0020, 32'h1122_3344);
`endif

        check("no_dual_strobe", 32'(both_hi), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for the word-addressed data memory.
- Accepts one load/store request at a time from the execute/memory pipeline stage.
- Drives the memory's address, write data, mem_rd and mem_wd, and performs byte/halfword extraction and sign/zero extension.
- Implements sub-word stores as read-modify-write.
- Returns a single-cycle response with data or an error flag.

Parameters:
- BASE_ADDR, 32'h00400000: first byte address mapped to memory word 0.
- DEPTH_WORDS, 64: number of 32-bit words; valid range is BASE_ADDR to BASE_ADDR+4*DEPTH_WORDS-1.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: unit can accept a request (high only in IDLE).
- req_op, input, 3: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data; low byte or halfword used for SB/SH.
- resp_valid, output, 1: one-cycle response pulse.
- resp_rdata, output, 32: extended load data; 0 for stores and errors.
- resp_err, output, 1: misaligned or out-of-range request; valid with resp_valid.
- mem_dir, output, 32: word-aligned address to memory.
- mem_data_in, output, 32: write word to memory.
- mem_rd, output, 1: memory read strobe.
- mem_wd, output, 1: memory write strobe.
- mem_data_out, input, 32: memory read data, valid from the falling edge of a cycle with mem_rd high until the next falling edge.

Behaviour:
- Reset (rst high at posedge): state IDLE. req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_dir=0, mem_data_in=0.
- mem_rd and mem_wd are combinationally gated with !rst. No memory access is issued in any cycle where rst is high, including reset arriving mid read-modify-write; a partially completed RMW leaves memory unchanged.
- States: IDLE, READ, WRITE, RESP.
- IDLE: on req_valid && req_ready, register op, addr, wdata; compute err, then:
  - err: go to RESP.
  - LB/LH/LW/LBU/LHU/SB/SH: go to READ.
  - SW: go to WRITE.
- READ:
  - mem_rd=1, mem_dir = {addr[31:2],2'b00}.
  - At posedge, capture mem_data_out (settled at the preceding negedge).
  - Loads go to RESP; SB/SH go to WRITE.
- WRITE:
  - mem_wd=1, mem_dir as above, mem_data_in = merged word; go to RESP.
  - SW merge: wdata.
  - SH merge: replace half addr[1] (0 = bits 15:0, 1 = bits 31:16) with wdata[15:0].
  - SB merge: replace byte lane addr[1:0] (lane 0 = bits 7:0) with wdata[7:0].
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Byte order is little-endian. Load extraction uses the same lanes; LB/LH sign-extend, LBU/LHU zero-extend.
- Error conditions:
  - addr < BASE_ADDR, or addr > BASE_ADDR+4*DEPTH_WORDS-1.
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - On error: no memory strobe, resp_rdata=0, resp_err=1.
- Latency from accept cycle to resp_valid:
  - Error: 1 cycle.
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
- mem_dir and mem_data_in are driven from registered state only and are stable across the whole strobe cycle. mem_rd and mem_wd are never both high.
- req_valid while not ready is ignored; the requester must hold it until accepted.
- Address arithmetic is 32-bit unsigned. The range check must not wrap: BASE_ADDR+4*DEPTH_WORDS is computed at 33 bits.

Optional Feature:
- Macro: LSU_SUBWORD_EN.
- Defined: full op set as above.
- Undefined:
  - Ops 0, 1, 3, 4, 5, 6 return resp_err=1 after 1 cycle with no memory access.
  - LW/SW behave identically to the defined case.
  - The merge and extension logic is omitted.

Decomposition:
- Shared package lsu_pkg:
  - op encodings (LSU_LB..LSU_SW).
  - state encodings.
  - default BASE_ADDR and DEPTH_WORDS constants.
- Sub-module lsu_lane_align (combinational), compiled only under LSU_SUBWORD_EN:
  - load path: word + op + addr[1:0] → extended data.
  - store path: old word + wdata + op + addr[1:0] → merged word.

Test Plan:
- Reset mid-SB: rst high during the WRITE cycle → mem_wd=0 that cycle; the word stays 32'h11223344; next cycle IDLE and req_ready=1.
- SW addr 0x00400008, data 32'hDEADBEEF, then LW same addr → mem_wd pulse at cycle 1; LW resp_rdata=32'hDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- With word 32'h80FF7F01 at 0x00400010:
  - LB addr 0x00400013 → 32'hFFFFFF80.
  - LBU same addr → 32'h00000080.
  - LH addr 0x00400012 → 32'hFFFF80FF.
  - LHU addr 0x00400010 → 32'h00007F01.
- SB 0xAA to 0x00400011 over 32'h11223344 → one mem_rd cycle then one mem_wd cycle with mem_data_in=32'h1122AA44; resp at cycle 3.
- Errors, each → resp_err=1 after 1 cycle, no strobes:
  - LW 0x00400002.
  - SH 0x00400001.
  - LW 0x003FFFFC.
  - SW 0x00400100.
- LSU_SUBWORD_EN undefined: LB 0x00400000 → resp_err=1, no mem_rd; LW still returns stored data.
